vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen_if.sv | 18 +
 rtl/vga_timing_gen.sv | 86 ++++++++
 tb/tb_vga_timing_gen.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Output bundle of the 640x480@60 timing generator.
// master: the generator drives it; slave: a pixel consumer samples it.
interface vga_timing_gen_if;
  logic [9:0] current_row;
  logic [9:0] current_line;
  logic       enable;
  logic       hsync;
  logic       vsync;
  logic       pixel_tick;
  logic       frame_start;

  modport master (
    output current_row, current_line, enable, hsync, vsync, pixel_tick, frame_start
  );
  modport slave (
    input  current_row, current_line, enable, hsync, vsync, pixel_tick, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator.
// A clock divider produces a one-cycle pixel_tick every CLK_DIV clocks.
// Row and line counters advance on that tick.
// Decoded outputs come from the next-state counts, so they line up with the counters.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  vga_timing_gen_if.master vga
);

  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd751;
  localparam logic [9:0] H_MAX    = 10'd799;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd491;
  localparam logic [9:0] V_MAX    = 10'd524;
  localparam logic [3:0] DIV_MAX  = 4'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be 1..16");
  end

  logic [3:0] div_q, div_d;
  logic [9:0] row_q, row_d;
  logic [9:0] line_q, line_d;
  logic       tick_q, tick_d;
  logic       en_q, en_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       fs_q, fs_d;
  logic       row_wrap;

  // Next-state: divider, counters (an out-of-range count wraps to 0), and decodes of the next counts
  always_comb begin
    div_d    = (div_q >= DIV_MAX) ? 4'd0 : div_q + 4'd1;
    tick_d   = (div_d == DIV_MAX);
    row_d    = row_q;
    line_d   = line_q;
    row_wrap = tick_q && (row_q >= H_MAX);
    if (tick_q) begin
      row_d = (row_q >= H_MAX) ? 10'd0 : row_q + 10'd1;
      if (row_q >= H_MAX)
        line_d = (line_q >= V_MAX) ? 10'd0 : line_q + 10'd1;
    end
    fs_d = row_wrap && (line_q >= V_MAX);
    en_d = (row_d < H_VIS) && (line_d < V_VIS);
    hs_d = !((row_d >= H_SYNC_S) && (row_d <= H_SYNC_E));
    vs_d = !((line_d >= V_SYNC_S) && (line_d <= V_SYNC_E));
  end

  // State and registered outputs; synchronous reset overrides everything
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      div_q  <= 4'd0;
      row_q  <= 10'd0;
      line_q <= 10'd0;
      tick_q <= 1'b0;
      en_q   <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      row_q  <= row_d;
      line_q <= line_d;
      tick_q <= tick_d;
      en_q   <= en_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fs_q   <= fs_d;
    end
  end

  assign vga.current_row  = row_q;
  assign vga.current_line = line_q;
  assign vga.enable       = en_q;
  assign vga.hsync        = hs_q;
  assign vga.vsync        = vs_q;
  assign vga.pixel_tick   = tick_q;
  assign vga.frame_start  = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen.
// Two instances share one clock and reset: CLK_DIV=4 and CLK_DIV=1.
// The driver applies random reset pulses.
// For each edge it pushes the expected outputs, derived from elapsed cycles since reset release.
// A monitor pops the expected values and compares them just after each rising edge.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] row;
    logic [9:0] line;
    logic       en;
    logic       hs;
    logic       vs;
    logic       tk;
    logic       fs;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_n_in;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q4[$];
  exp_t q1[$];

  vga_timing_gen_if if4 ();
  vga_timing_gen_if if1 ();

  vga_timing_gen #(.CLK_DIV(4)) dut4 (.clk_in(clk_in), .rst_n_in(rst_n_in), .vga(if4));
  vga_timing_gen #(.CLK_DIV(1)) dut1 (.clk_in(clk_in), .rst_n_in(rst_n_in), .vga(if1));

  always #5 clk_in = ~clk_in;

  // Pixel ticks consumed after c edges out of reset.
  // Ticks land on edges 2..c whose index is a multiple of D.
  function automatic int ticks(input int c, input int d);
    if (c < 1) return 0;
    return (d == 1) ? c - 1 : c / d;
  endfunction

  // Expected outputs after the c-th edge since release (c=0 means the edge was in reset)
  function automatic exp_t model(input int c, input int d);
    exp_t e;
    int   t, pix;
    if (c == 0) begin
      e = '{row: 10'd0, line: 10'd0, en: 1'b0, hs: 1'b1, vs: 1'b1, tk: 1'b0, fs: 1'b0};
      return e;
    end
    t      = ticks(c, d);
    pix    = t % 420000;
    e.row  = 10'(pix % 800);
    e.line = 10'(pix / 800);
    e.en   = (e.row < 640) && (e.line < 480);
    e.hs   = !((e.row >= 656) && (e.row <= 751));
    e.vs   = !((e.line >= 490) && (e.line <= 491));
    e.tk   = ((c % d) == d - 1);
    e.fs   = (t > 0) && (pix == 0) && (t != ticks(c - 1, d));
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Driver: at each falling edge choose reset for the next rising edge and queue its expectation
  int c = 0;
  task automatic step(input bit r);
    @(negedge clk_in);
    rst_n_in = r;
    if (!r) c = 0;
    else    c++;
    q4.push_back(model(c, 4));
    q1.push_back(model(c, 1));
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b1);
  endtask

  task automatic rst(input int n);
    repeat (n) step(1'b0);
  endtask

  // Monitor: compare every output of both instances just after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      cyc++;
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("row4",  int'(if4.current_row),  int'(e.row));
        chk("line4", int'(if4.current_line), int'(e.line));
        chk("en4",   int'(if4.enable),       int'(e.en));
        chk("hs4",   int'(if4.hsync),        int'(e.hs));
        chk("vs4",   int'(if4.vsync),        int'(e.vs));
        chk("tk4",   int'(if4.pixel_tick),   int'(e.tk));
        chk("fs4",   int'(if4.frame_start),  int'(e.fs));
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("row1",  int'(if1.current_row),  int'(e.row));
        chk("line1", int'(if1.current_line), int'(e.line));
        chk("en1",   int'(if1.enable),       int'(e.en));
        chk("hs1",   int'(if1.hsync),        int'(e.hs));
        chk("vs1",   int'(if1.vsync),        int'(e.vs));
        chk("tk1",   int'(if1.pixel_tick),   int'(e.tk));
        chk("fs1",   int'(if1.frame_start),  int'(e.fs));
      end
    end
  end

  initial begin
    int guard;
    rst_n_in = 1'b0;
    q4.push_back(model(0, 4));
    q1.push_back(model(0, 1));
    rst(3);
    // Release, then reset again before the divide-by-4 instance ticks
    run(2);
    rst(1);
    // Reset lands at row 700 of the divide-by-1 instance, inside its hsync pulse
    run(701);
    rst(1);
    // Long run across many lines of both instances
    run(45000);
    rst(2);
    repeat (3) begin
      run(int'($urandom_range(500, 6000)));
      rst(int'($urandom_range(1, 3)));
    end
    run(int'($urandom_range(800, 1500)));
    // Drain the scoreboard, with a bounded wait
    guard = 0;
    while ((q4.size() != 0 || q1.size() != 0) && guard < 10) begin
      @(negedge clk_in);
      guard++;
    end
    checks++;
    if (q4.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d entries left expected 0", q4.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
